// File: rtl/brush_pkg.sv
// Shared brush controller encodings: direction indices, per-direction FSM state
// and small helpers used by the scheduler.
package brush_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } dir_state_t;

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

    function automatic logic [2:0] evt_count(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/brush_dir_fsm.sv
// One direction's debounce / hold / auto-repeat state machine. Advances only on
// tick; move_evt is high during the tick cycle in which a move is due.
module brush_dir_fsm
    import brush_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 2,
    parameter int unsigned HOLD_TICKS     = 8,
    parameter int unsigned REPEAT_TICKS   = 2
) (
    input  logic Origin_Clock,
    input  logic reset,
    input  logic tick,
    input  logic btn_bit,
    output logic move_evt
);

    localparam int unsigned MAX_DH    = (DEBOUNCE_TICKS > HOLD_TICKS) ? DEBOUNCE_TICKS : HOLD_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_DH > REPEAT_TICKS) ? MAX_DH : REPEAT_TICKS;
    localparam int unsigned C_W       = $clog2(MAX_TICKS + 1);

    dir_state_t     state;
    logic [C_W-1:0] cnt;
    logic [31:0]    cnt_inc;

    assign cnt_inc = 32'(cnt) + 32'd1;

    // ARM is entered with c=1, so ">=" lets a single-tick debounce fire at once
    always_comb begin
        move_evt = 1'b0;
        if (tick && btn_bit) begin
            case (state)
                ARM:     move_evt = (cnt_inc >= DEBOUNCE_TICKS);
                HOLD:    move_evt = (cnt_inc == HOLD_TICKS);
                REPEAT:  move_evt = (cnt_inc == REPEAT_TICKS);
                default: move_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Origin_Clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (tick) begin
            if (!btn_bit) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        cnt   <= C_W'(1);
                    end
                    ARM: begin
                        if (move_evt) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (move_evt) begin
                            state <= REPEAT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (move_evt) cnt <= '0;
                        else          cnt <= cnt + 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/brush_tick_scheduler.sv
// Base-tick divider, four direction FSMs and a round-robin valid/ready move arbiter.
// Optional BRUSH_DROP_CNT_EN adds a saturating count of merged move events.
module brush_tick_scheduler
    import brush_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 500000,
    parameter int unsigned TICK_PHASE     = 299999,
    parameter int unsigned DEBOUNCE_TICKS = 2,
    parameter int unsigned HOLD_TICKS     = 8,
    parameter int unsigned REPEAT_TICKS   = 2,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       Origin_Clock,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       tick
`ifdef BRUSH_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    logic [CNT_W-1:0] count;
    logic [3:0]       move_evt;
    logic [3:0]       pend;
    logic [3:0]       grant_clr;
    logic [1:0]       last_grant;
    logic [1:0]       grant_dir;
    logic [1:0]       probe;
    logic             grant_hit;
    logic             grant_now;

    assign tick = (count == CNT_W'(TICK_PHASE));

    for (genvar d = 0; d < 4; d++) begin : g_dir
        brush_dir_fsm #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .HOLD_TICKS     (HOLD_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_fsm (
            .Origin_Clock (Origin_Clock),
            .reset        (reset),
            .tick         (tick),
            .btn_bit      (btn[d]),
            .move_evt     (move_evt[d])
        );
    end

    // Round-robin search starting just after the last granted direction
    always_comb begin
        grant_hit = 1'b0;
        grant_dir = last_grant;
        probe     = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            probe = last_grant + 2'(i);
            if (!grant_hit && pend[probe]) begin
                grant_hit = 1'b1;
                grant_dir = probe;
            end
        end
    end

    assign grant_now = !move_valid && grant_hit;
    assign grant_clr = grant_now ? dir_onehot(grant_dir) : '0;

    always_ff @(posedge Origin_Clock) begin
        if (!reset) begin
            count      <= '0;
            pend       <= '0;
            move_valid <= 1'b0;
            move_dir   <= DIR_UP;
            last_grant <= DIR_RIGHT;
        end else begin
            count <= (count == CNT_W'(CLK_DIV - 1)) ? '0 : count + 1'b1;
            // A new event wins over the grant clearing the same bit
            pend  <= (pend & ~grant_clr) | move_evt;
            if (move_valid) begin
                if (move_ready) move_valid <= 1'b0;
            end else if (grant_hit) begin
                move_valid <= 1'b1;
                move_dir   <= grant_dir;
                last_grant <= grant_dir;
            end
        end
    end

`ifdef BRUSH_DROP_CNT_EN
    logic [3:0] merged;
    logic [8:0] drop_sum;

    // An event landing on a bit that is being granted this cycle is not lost
    assign merged   = move_evt & pend & ~grant_clr;
    assign drop_sum = {1'b0, drop_cnt} + 9'(evt_count(merged));

    always_ff @(posedge Origin_Clock) begin
        if (!reset) drop_cnt <= '0;
        else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_brush_tick_scheduler.sv
// Directed bench for brush_tick_scheduler with a 10-cycle tick period;
// drop counter checks are included when BRUSH_DROP_CNT_EN is defined.
module tb_brush_tick_scheduler;

    logic       Origin_Clock = 1'b0;
    logic       reset        = 1'b0;
    logic [3:0] btn          = 4'b0000;
    logic       move_ready   = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       tick;
`ifdef BRUSH_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    brush_tick_scheduler #(
        .CLK_DIV        (10),
        .TICK_PHASE     (6),
        .DEBOUNCE_TICKS (2),
        .HOLD_TICKS     (4),
        .REPEAT_TICKS   (2),
        .CNT_W          (8)
    ) dut (
        .Origin_Clock (Origin_Clock),
        .reset        (reset),
        .btn          (btn),
        .move_ready   (move_ready),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .tick         (tick)
`ifdef BRUSH_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 Origin_Clock = ~Origin_Clock;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, c, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Origin_Clock);
        #1;
    endtask

    // Leaves the bench in cycle 0: registers freshly reset, reset released
    task automatic do_reset();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        chk("rst_valid", 0, 32'(move_valid), 32'd0);
        chk("rst_dir",   0, 32'(move_dir),   32'd0);
        chk("rst_tick",  0, 32'(tick),       32'd0);
    endtask

    // Held-down scenario: hand-derived valid windows and ready schedule
    function automatic bit down_valid(int c);
        return c == 18 || c == 58 || c == 78 || (c >= 98 && c <= 140) ||
               c == 142 || c == 158 || (c >= 178 && c <= 196) ||
               (c >= 198 && c <= 235) || c == 237 || c == 239 || c == 258;
    endfunction

    function automatic bit down_ready(int c);
        return c <= 94 || (c >= 140 && c <= 159) || c == 196 || c >= 235;
    endfunction

    initial begin
        // Divider, tick phase and mid-run reset
        btn = 4'b0000;
        move_ready = 1'b0;
        do_reset();
        for (int c = 0; c <= 23; c++) begin
            chk("tick_phase", c, 32'(tick), 32'(c % 10 == 6));
            chk("idle_valid", c, 32'(move_valid), 32'd0);
            if (c < 23) next_cycle();
        end
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            chk("tick_after_rst", c, 32'(tick), 32'(c == 6));
            next_cycle();
        end

        // Left held: first move, hold delay, repeat, release
        btn = 4'b0100;
        move_ready = 1'b1;
        do_reset();
        for (int c = 0; c <= 130; c++) begin
            if (c == 101) btn = 4'b0000;
            chk("left_valid", c, 32'(move_valid), 32'(c == 18 || c == 58 || c == 78 || c == 98));
            if (move_valid) chk("left_dir", c, 32'(move_dir), 32'd2);
            next_cycle();
        end

        // Up glitch over one tick, then a real press from IDLE
        btn = 4'b0000;
        do_reset();
        for (int c = 0; c <= 62; c++) begin
            if (c == 5)  btn = 4'b0001;
            if (c == 7)  btn = 4'b0000;
            if (c == 41) btn = 4'b0001;
            chk("glitch_valid", c, 32'(move_valid), 32'(c == 58));
            if (c == 58) chk("glitch_dir", c, 32'(move_dir), 32'd0);
            next_cycle();
        end

        // Up and right together: alternate, up first after reset
        btn = 4'b1001;
        do_reset();
        for (int c = 0; c <= 85; c++) begin
            chk("pair_valid", c, 32'(move_valid),
                32'(c == 18 || c == 20 || c == 58 || c == 60 || c == 78 || c == 80));
            if (c == 18 || c == 58 || c == 78) chk("pair_dir_up",    c, 32'(move_dir), 32'd0);
            if (c == 20 || c == 60 || c == 80) chk("pair_dir_right", c, 32'(move_dir), 32'd3);
            next_cycle();
        end

        // Down held: stall with merge, handshake on re-set, set-wins-over-clear
        btn = 4'b0010;
        do_reset();
        for (int c = 0; c <= 262; c++) begin
            move_ready = down_ready(c);
            chk("down_valid", c, 32'(move_valid), 32'(down_valid(c)));
            if (down_valid(c)) chk("down_dir", c, 32'(move_dir), 32'd1);
            next_cycle();
        end

`ifdef BRUSH_DROP_CNT_EN
        chk("drop_one", 263, 32'(drop_cnt), 32'd1);
        move_ready = 1'b0;
        repeat (5400) next_cycle();
        chk("drop_sat", 5663, 32'(drop_cnt), 32'd255);
        repeat (200) next_cycle();
        chk("drop_hold", 5863, 32'(drop_cnt), 32'd255);
        chk("drop_valid_held", 5863, 32'(move_valid), 32'd1);
        do_reset();
        chk("drop_rst", 0, 32'(drop_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
